// File: rtl/ff2_sync.sv
// -----------------------------------------------------------------------------
// ff2_sync -- multi-flop synchronizer for level signals crossing into `clk`.
//
// Every lane is synchronized on its own. No coherency is guaranteed between
// lanes, so a multi-bit bus must not be passed through here as a value.
// The whole chain clocks on a single edge, chosen by NEG_EDGE. Set NEG_EDGE=1
// when the destination logic runs on the falling edge (I2S bck, bus clocks).
//
// Parameters:
//   WIDTH     number of independent single-bit lanes
//   STAGES    flop stages per lane, 2..4 (anything else fails elaboration)
//   NEG_EDGE  0 = posedge clk, 1 = negedge clk
//   RESET_VAL value loaded into every stage while rst is high
//
// Ports:
//   clk     in   destination-domain clock
//   rst     in   asynchronous active-high reset; release is taken on the
//                active edge
//   d       in   WIDTH  asynchronous level input from a foreign domain
//   q       out  WIDTH  synchronized level (last stage, pure flop output)
//   q_rise  out  WIDTH  one-cycle pulse when q goes 0->1 (FF2_SYNC_EDGE_DET_EN)
//   q_fall  out  WIDTH  one-cycle pulse when q goes 1->0 (FF2_SYNC_EDGE_DET_EN)
//
// Build option: define FF2_SYNC_EDGE_DET_EN to add the previous-q register and
// the q_rise / q_fall pulse outputs. Without it only q exists.
// -----------------------------------------------------------------------------
module ff2_sync #(
    parameter int                WIDTH     = 1,
    parameter int                STAGES    = 2,
    parameter int                NEG_EDGE  = 0,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
`ifdef FF2_SYNC_EDGE_DET_EN
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
`endif
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("ff2_sync: STAGES must be in the range 2..4");
        end
        if (NEG_EDGE != 0 && NEG_EDGE != 1) begin : g_bad_edge
            $error("ff2_sync: NEG_EDGE must be 0 or 1");
        end
    endgenerate

    // Index 0 is the metastability-catching stage. All stages are tagged so
    // placement keeps them adjacent; nothing else may sit between them.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    // Pure shift: new sample enters at index 0, everything moves up one.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

`ifdef FF2_SYNC_EDGE_DET_EN
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] p_d;

    always_comb begin
        p_d = sync_q[STAGES-1];
    end
`endif

    // The two branches are identical except for the sensitivity edge. The
    // previous-q register resets to RESET_VAL, the same value as q, so no
    // pulse appears at reset release.
    generate
        if (NEG_EDGE != 0) begin : g_neg
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= {STAGES{RESET_VAL}};
`ifdef FF2_SYNC_EDGE_DET_EN
                    p_q    <= RESET_VAL;
`endif
                end else begin
                    sync_q <= sync_d;
`ifdef FF2_SYNC_EDGE_DET_EN
                    p_q    <= p_d;
`endif
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= {STAGES{RESET_VAL}};
`ifdef FF2_SYNC_EDGE_DET_EN
                    p_q    <= RESET_VAL;
`endif
                end else begin
                    sync_q <= sync_d;
`ifdef FF2_SYNC_EDGE_DET_EN
                    p_q    <= p_d;
`endif
                end
            end
        end
    endgenerate

    assign q = sync_q[STAGES-1];

`ifdef FF2_SYNC_EDGE_DET_EN
    assign q_rise = sync_q[STAGES-1] & ~p_q;
    assign q_fall = ~sync_q[STAGES-1] & p_q;
`endif

endmodule

// File: tb/tb_ff2_sync.sv
// -----------------------------------------------------------------------------
// tb_ff2_sync -- self-checking bench for ff2_sync.
// Instances: default posedge (W1,S2), negedge (W1,S2), W4/S3/RESET_VAL=1010,
// W2/S4/RESET_VAL=01, and a two-clock req/ack handshake pair.
// -----------------------------------------------------------------------------
module tb_ff2_sync;

    logic clk, clk_a, clk_b, rst;
    logic       d_pos, d_neg;
    logic [3:0] d_s3;
    logic [1:0] d_s4;
    logic       q_pos, q_neg;
    logic [3:0] q_s3;
    logic [1:0] q_s4;
    logic       hs_req, hs_req_b, hs_ack_a;
    logic       hs_active;
    int         ack_toggles;
`ifdef FF2_SYNC_EDGE_DET_EN
    logic       r_pos, f_pos, r_neg, f_neg, r_hb, f_hb, r_ha, f_ha;
    logic [3:0] r_s3, f_s3;
    logic [1:0] r_s4, f_s4;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    ff2_sync u_pos (
        .clk(clk), .rst(rst), .d(d_pos),
`ifdef FF2_SYNC_EDGE_DET_EN
        .q_rise(r_pos), .q_fall(f_pos),
`endif
        .q(q_pos));

    ff2_sync #(.NEG_EDGE(1)) u_neg (
        .clk(clk), .rst(rst), .d(d_neg),
`ifdef FF2_SYNC_EDGE_DET_EN
        .q_rise(r_neg), .q_fall(f_neg),
`endif
        .q(q_neg));

    ff2_sync #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'b1010)) u_s3 (
        .clk(clk), .rst(rst), .d(d_s3),
`ifdef FF2_SYNC_EDGE_DET_EN
        .q_rise(r_s3), .q_fall(f_s3),
`endif
        .q(q_s3));

    ff2_sync #(.WIDTH(2), .STAGES(4), .RESET_VAL(2'b01)) u_s4 (
        .clk(clk), .rst(rst), .d(d_s4),
`ifdef FF2_SYNC_EDGE_DET_EN
        .q_rise(r_s4), .q_fall(f_s4),
`endif
        .q(q_s4));

    // req crosses into the clk_b domain on its falling edge, ack returns
    // into clk_a on its rising edge.
    ff2_sync #(.NEG_EDGE(1)) u_hs_b (
        .clk(clk_b), .rst(rst), .d(hs_req),
`ifdef FF2_SYNC_EDGE_DET_EN
        .q_rise(r_hb), .q_fall(f_hb),
`endif
        .q(hs_req_b));

    ff2_sync u_hs_a (
        .clk(clk_a), .rst(rst), .d(hs_req_b),
`ifdef FF2_SYNC_EDGE_DET_EN
        .q_rise(r_ha), .q_fall(f_ha),
`endif
        .q(hs_ack_a));

    initial begin clk = 1'b0;   forever #5   clk   = ~clk;   end
    initial begin clk_a = 1'b0; forever #100 clk_a = ~clk_a; end
    initial begin clk_b = 1'b0; #50; forever #200 clk_b = ~clk_b; end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(hs_ack_a) if (hs_active) ack_toggles <= ack_toggles + 1;

    // Reference model: q after active edge n equals the d sampled at edge
    // n-STAGES+1, or RESET_VAL when fewer than STAGES edges have passed since
    // reset. "prev" is the same one edge earlier.
    logic [3:0] h_pos[$], h_neg[$], h_s3[$], h_s4[$];
    logic [3:0] m_pos, m_neg, m_s3, m_s4;
    logic [3:0] mp_pos, mp_neg, mp_s3, mp_s4;

    always @(posedge clk or posedge rst) begin
        if (rst) h_pos.delete();
        else begin
            h_pos.push_back(4'(d_pos));
            if (h_pos.size() > 8) void'(h_pos.pop_front());
        end
        m_pos  <= (h_pos.size() >= 2) ? h_pos[h_pos.size()-2] : 4'h0;
        mp_pos <= (h_pos.size() >= 3) ? h_pos[h_pos.size()-3] : 4'h0;
    end

    always @(negedge clk or posedge rst) begin
        if (rst) h_neg.delete();
        else begin
            h_neg.push_back(4'(d_neg));
            if (h_neg.size() > 8) void'(h_neg.pop_front());
        end
        m_neg  <= (h_neg.size() >= 2) ? h_neg[h_neg.size()-2] : 4'h0;
        mp_neg <= (h_neg.size() >= 3) ? h_neg[h_neg.size()-3] : 4'h0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) h_s3.delete();
        else begin
            h_s3.push_back(d_s3);
            if (h_s3.size() > 8) void'(h_s3.pop_front());
        end
        m_s3  <= (h_s3.size() >= 3) ? h_s3[h_s3.size()-3] : 4'hA;
        mp_s3 <= (h_s3.size() >= 4) ? h_s3[h_s3.size()-4] : 4'hA;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) h_s4.delete();
        else begin
            h_s4.push_back(4'(d_s4));
            if (h_s4.size() > 8) void'(h_s4.pop_front());
        end
        m_s4  <= (h_s4.size() >= 4) ? h_s4[h_s4.size()-4] : 4'h1;
        mp_s4 <= (h_s4.size() >= 5) ? h_s4[h_s4.size()-5] : 4'h1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic check_all();
        chk("pos_q", 32'(q_pos), 32'(m_pos));
        chk("neg_q", 32'(q_neg), 32'(m_neg));
        chk("s3_q",  32'(q_s3),  32'(m_s3));
        chk("s4_q",  32'(q_s4),  32'(m_s4));
`ifdef FF2_SYNC_EDGE_DET_EN
        chk("pos_rise", 32'(r_pos), 32'(m_pos & ~mp_pos));
        chk("pos_fall", 32'(f_pos), 32'(~m_pos & mp_pos & 4'h1));
        chk("neg_rise", 32'(r_neg), 32'(m_neg & ~mp_neg));
        chk("neg_fall", 32'(f_neg), 32'(~m_neg & mp_neg & 4'h1));
        chk("s3_rise",  32'(r_s3),  32'(m_s3 & ~mp_s3));
        chk("s3_fall",  32'(f_s3),  32'(~m_s3 & mp_s3));
        chk("s4_rise",  32'(r_s4),  32'(m_s4 & ~mp_s4));
        chk("s4_fall",  32'(f_s4),  32'(~m_s4 & mp_s4 & 4'h3));
`endif
    endtask

    typedef struct {
        logic       rst;
        logic       d1;
        logic [3:0] d4;
        logic       e1;
        logic [3:0] e4;
    } vec_t;
    vec_t tbl[12];

    initial begin
        // Applied mid-cycle; e1/e4 are q_pos/q_s3 after the following posedge.
        tbl[0]  = '{rst:1'b1, d1:1'b0, d4:4'h0, e1:1'b0, e4:4'hA};
        tbl[1]  = '{rst:1'b1, d1:1'b0, d4:4'h5, e1:1'b0, e4:4'hA};
        tbl[2]  = '{rst:1'b0, d1:1'b1, d4:4'h5, e1:1'b0, e4:4'hA};
        tbl[3]  = '{rst:1'b0, d1:1'b1, d4:4'h5, e1:1'b1, e4:4'hA};
        tbl[4]  = '{rst:1'b0, d1:1'b0, d4:4'hF, e1:1'b1, e4:4'h5};
        tbl[5]  = '{rst:1'b0, d1:1'b0, d4:4'h0, e1:1'b0, e4:4'h5};
        tbl[6]  = '{rst:1'b0, d1:1'b1, d4:4'h0, e1:1'b0, e4:4'hF};
        tbl[7]  = '{rst:1'b0, d1:1'b0, d4:4'h3, e1:1'b1, e4:4'h0};
        tbl[8]  = '{rst:1'b0, d1:1'b0, d4:4'h3, e1:1'b0, e4:4'h0};
        tbl[9]  = '{rst:1'b0, d1:1'b1, d4:4'h3, e1:1'b0, e4:4'h3};
        tbl[10] = '{rst:1'b0, d1:1'b1, d4:4'h3, e1:1'b1, e4:4'h3};
        tbl[11] = '{rst:1'b0, d1:1'b1, d4:4'h3, e1:1'b1, e4:4'h3};

        rst = 1'b1; d_pos = 1'b0; d_neg = 1'b0; d_s3 = 4'h0; d_s4 = 2'h0;
        hs_req = 1'b0; hs_active = 1'b0; ack_toggles = 0;

        // Table: reset state, 2-edge and 3-edge latency.
        @(posedge clk); #2;
        for (int k = 0; k < 12; k++) begin
            rst = tbl[k].rst; d_pos = tbl[k].d1; d_s3 = tbl[k].d4;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_pos_q", k), 32'(q_pos), 32'(tbl[k].e1));
            chk($sformatf("tbl%0d_s3_q", k),  32'(q_s3),  32'(tbl[k].e4));
            #1;
        end

        // Asynchronous reset between edges with q=1, d=1.
        #1 rst = 1'b1;
        #1;
        chk("async_pos_q", 32'(q_pos), 32'h0);
        chk("async_s3_q",  32'(q_s3),  32'hA);
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_pos_q", 32'(q_pos), 32'h0);
            chk("hold_s3_q",  32'(q_s3),  32'hA);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rel1_pos_q", 32'(q_pos), 32'h0);
`ifdef FF2_SYNC_EDGE_DET_EN
        chk("rel1_pos_rise", 32'(r_pos), 32'h0);
        chk("rel1_s3_fall",  32'(f_s3),  32'h0);
`endif
        @(posedge clk); #1;
        chk("rel2_pos_q", 32'(q_pos), 32'h1);
        chk("rel2_s3_q",  32'(q_s3),  32'hA);
        @(posedge clk); #1;
        chk("rel3_s3_q",  32'(q_s3),  32'h3);

        // Negedge variant: changes only after negedges, two of them.
        #1 d_neg = 1'b1;
        @(negedge clk); #1 chk("neg_up_n1", 32'(q_neg), 32'h0);
        @(posedge clk); #1 chk("neg_up_p1", 32'(q_neg), 32'h0);
        @(negedge clk); #1 chk("neg_up_n2", 32'(q_neg), 32'h1);
        @(posedge clk); #1 chk("neg_up_p2", 32'(q_neg), 32'h1);
        #1 d_neg = 1'b0;
        @(negedge clk); #1 chk("neg_dn_n1", 32'(q_neg), 32'h1);
        @(posedge clk); #1 chk("neg_dn_p1", 32'(q_neg), 32'h1);
        @(negedge clk); #1 chk("neg_dn_n2", 32'(q_neg), 32'h0);

`ifdef FF2_SYNC_EDGE_DET_EN
        // Edge pulses on a 1->0->1 walk of the default instance.
        @(posedge clk); #2 d_pos = 1'b0;
        @(posedge clk); #1 chk("ed_f0", 32'({r_pos, f_pos}), 32'h0);
        @(posedge clk); #1 chk("ed_f1", 32'({r_pos, f_pos}), 32'h1);
        @(posedge clk); #1 chk("ed_f2", 32'({r_pos, f_pos}), 32'h0);
        #1 d_pos = 1'b1;
        @(posedge clk); #1 chk("ed_r0", 32'({r_pos, f_pos}), 32'h0);
        @(posedge clk); #1 chk("ed_r1", 32'({r_pos, f_pos}), 32'h2);
        @(posedge clk); #1 chk("ed_r2", 32'({r_pos, f_pos}), 32'h0);
`endif

        // Randomized levels and occasional async resets against the model,
        // sampled after both clock edges.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            check_all();
            #1;
            rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) d_pos = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) d_neg = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) d_s3  = 4'($urandom);
            if ($urandom_range(0, 2) == 0) d_s4  = 2'($urandom);
            @(negedge clk); #1;
            check_all();
        end
        rst = 1'b0;

        // req/ack loop across the 5 MHz / 2.5 MHz pair.
        @(posedge clk_a); #1;
        hs_active = 1'b1;
        for (int it = 0; it < 100; it++) begin
            int n;
            int m;
            hs_req = ~hs_req;
            n = 0;
            while (hs_req_b !== hs_req && n < 8) begin
                @(negedge clk_b); #1; n++;
            end
            chk("hs_req_edges", 32'(n), 32'd2);
            m = 0;
            while (hs_ack_a !== hs_req && m < 8) begin
                @(posedge clk_a); #1; m++;
            end
            chk("hs_ack_edges", 32'(m), 32'd2);
        end
        #1;
        chk("hs_ack_toggles", 32'(ack_toggles), 32'd100);
        chk("hs_final_ack", 32'(hs_ack_a), 32'(hs_req));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
